// File: rtl/prbs_ctrl_pkg.sv
// Shared types and constants for the PRBS lane-scan sequencer.
package prbs_ctrl_pkg;

    typedef enum logic [2:0] {
        StIdle,
        StSettle,
        StCheck,
        StNext,
        StDone
    } scan_state_e;

    // Checker powers up flagging errors and needs history plus a 2-cycle pipeline.
    localparam int unsigned MIN_SETTLE_CYC = 3;

    function automatic int unsigned lsel_w(int unsigned n);
        return (n > 2) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/prbs_sat_cnt.sv
// Generic saturating up-counter with synchronous clear and count enable.
module prbs_sat_cnt #(
    parameter int unsigned WIDTH = 8
) (
    input  logic             clk_i,
    input  logic             resetn_i,
    input  logic             clr_i,
    input  logic             en_i,
    output logic [WIDTH-1:0] cnt_o
);

    logic [WIDTH-1:0] r_cnt;

    always_ff @(posedge clk_i or negedge resetn_i) begin
        if (!resetn_i) begin
            r_cnt <= '0;
        end else if (clr_i) begin
            r_cnt <= '0;
        end else if (en_i && (r_cnt != '1)) begin
            r_cnt <= r_cnt + 1'b1;
        end
    end

    assign cnt_o = r_cnt;

endmodule

// File: rtl/prbs_lane_scan_ctrl.sv
// Scans NLANES receive lanes through one shared PRBS checker, recording a
// per-lane pass flag and saturating error count.
module prbs_lane_scan_ctrl
    import prbs_ctrl_pkg::*;
#(
    parameter int unsigned NLANES     = 4,
    parameter int unsigned SETTLE_CYC = 16,
    parameter int unsigned CHECK_CYC  = 1024,
    parameter int unsigned ERR_CNT_W  = 8,
    localparam int unsigned LSEL_W    = lsel_w(NLANES)
) (
    input  logic                        clk_i,
    input  logic                        resetn_i,
    input  logic                        start_i,
    input  logic                        abort_i,
    input  logic                        prbs_err_i,
    output logic                        prbs_en_o,
    output logic [LSEL_W-1:0]           lane_sel_o,
    output logic                        busy_o,
    output logic                        done_o,
    output logic [NLANES-1:0]           pass_o,
    output logic [NLANES*ERR_CNT_W-1:0] err_cnt_o
);

    localparam int unsigned TMR_MAX = (SETTLE_CYC > CHECK_CYC) ? SETTLE_CYC : CHECK_CYC;
    localparam int unsigned TMR_W   = $clog2(TMR_MAX);

    if (SETTLE_CYC < MIN_SETTLE_CYC || CHECK_CYC < 1 || NLANES < 2 || NLANES > 16)
    begin : g_param_chk
        $error("prbs_lane_scan_ctrl: illegal parameter set");
    end

    scan_state_e          r_state, w_state_d;
    logic [TMR_W-1:0]     w_tmr;
    logic [ERR_CNT_W-1:0] w_err_cnt;
    logic                 w_tmr_clr;
    logic                 w_start_ok;
    logic                 w_last_lane;
    logic                 r_prbs_en, r_busy, r_done;
    logic [LSEL_W-1:0]    r_lane_sel;
    logic [NLANES-1:0]    r_pass;
    logic [ERR_CNT_W-1:0] r_err_cnt [NLANES];

    assign w_start_ok  = start_i && !abort_i;
    assign w_last_lane = (r_lane_sel == LSEL_W'(NLANES - 1));

    always_comb begin
        w_state_d = r_state;
        unique case (r_state)
            StIdle:   if (w_start_ok) w_state_d = StSettle;
            StSettle: begin
                if (abort_i)                                    w_state_d = StIdle;
                else if (w_tmr == TMR_W'(SETTLE_CYC - 1))       w_state_d = StCheck;
            end
            StCheck:  begin
                if (abort_i)                                    w_state_d = StIdle;
                else if (w_tmr == TMR_W'(CHECK_CYC - 1))        w_state_d = StNext;
            end
            StNext:   begin
                if (abort_i)          w_state_d = StIdle;
                else if (w_last_lane) w_state_d = StDone;
                else                  w_state_d = StSettle;
            end
            StDone:   w_state_d = StIdle;
            default:  w_state_d = StIdle;
        endcase
    end

    // Phase timer restarts on every state change so each phase counts from zero.
    assign w_tmr_clr = (w_state_d != r_state) || !((r_state == StSettle) || (r_state == StCheck));

    prbs_sat_cnt #(
        .WIDTH (TMR_W)
    ) u_phase_tmr (
        .clk_i    (clk_i),
        .resetn_i (resetn_i),
        .clr_i    (w_tmr_clr),
        .en_i     (1'b1),
        .cnt_o    (w_tmr)
    );

    prbs_sat_cnt #(
        .WIDTH (ERR_CNT_W)
    ) u_err_cnt (
        .clk_i    (clk_i),
        .resetn_i (resetn_i),
        .clr_i    (r_state != StCheck),
        .en_i     ((r_state == StCheck) && prbs_err_i),
        .cnt_o    (w_err_cnt)
    );

    always_ff @(posedge clk_i or negedge resetn_i) begin
        if (!resetn_i) begin
            r_state   <= StIdle;
            r_prbs_en <= 1'b0;
            r_busy    <= 1'b0;
            r_done    <= 1'b0;
        end else begin
            r_state   <= w_state_d;
            r_prbs_en <= (w_state_d == StSettle) || (w_state_d == StCheck);
            r_busy    <= (w_state_d != StIdle);
            r_done    <= (w_state_d == StDone);
        end
    end

    always_ff @(posedge clk_i or negedge resetn_i) begin
        if (!resetn_i) begin
            r_lane_sel <= '0;
            r_pass     <= '0;
            for (int i = 0; i < int'(NLANES); i++) r_err_cnt[i] <= '0;
        end else if ((r_state == StIdle) && w_start_ok) begin
            r_lane_sel <= '0;
            r_pass     <= '0;
            for (int i = 0; i < int'(NLANES); i++) r_err_cnt[i] <= '0;
        end else if ((r_state == StNext) && !abort_i) begin
            r_err_cnt[r_lane_sel] <= w_err_cnt;
            r_pass[r_lane_sel]    <= (w_err_cnt == '0);
            if (!w_last_lane) r_lane_sel <= r_lane_sel + 1'b1;
        end
    end

    for (genvar g = 0; g < int'(NLANES); g++) begin : g_cnt_out
        assign err_cnt_o[g*ERR_CNT_W +: ERR_CNT_W] = r_err_cnt[g];
    end

    assign prbs_en_o  = r_prbs_en;
    assign lane_sel_o = r_lane_sel;
    assign busy_o     = r_busy;
    assign done_o     = r_done;
    assign pass_o     = r_pass;

endmodule

// File: doc/prbs_lane_scan_ctrl.md
# prbs_lane_scan_ctrl

Sequencer that shares one parallel-fabric PRBS checker across NLANES receive lanes. On start, it selects each lane in turn and enables the checker. It waits out the checker's flush and settle window, then counts error cycles over a fixed check window and records a per-lane pass/fail flag and error count. It sits between the lane data mux feeding the checker and the bit-align/training control that requests a link PRBS test.

## Interface
- NLANES, 4, number of lanes scanned, 2..16
- SETTLE_CYC, 16, cycles per lane with checker enabled and errors ignored; must be ≥ 3 (elaboration error otherwise)
- CHECK_CYC, 1024, cycles per lane during which errors are counted; ≥ 1
- ERR_CNT_W, 8, width of each lane error counter (saturating)
- LSEL_W, derived = max(1, clog2(NLANES)), not user-set
- clk_i  in  1  clock, all logic on rising edge
- resetn_i  in  1  asynchronous, active-low reset
- start_i  in  1  begin scan; sampled only in IDLE
- abort_i  in  1  terminate scan; returns to IDLE, no done pulse
- prbs_err_i  in  1  registered error flag from the shared checker
- prbs_en_o  out  1  checker enable
- lane_sel_o  out  LSEL_W  lane routed to the checker
- busy_o  out  1  high in every state except IDLE
- done_o  out  1  one-cycle pulse when all lanes are scanned
- pass_o  out  NLANES  bit n = lane n saw zero errors in CHECK
- err_cnt_o  out  NLANES*ERR_CNT_W  lane n count at bits [n*ERR_CNT_W +: ERR_CNT_W]

## Operation
- States: IDLE, SETTLE, CHECK, NEXT, DONE.
- IDLE: on start_i=1 and abort_i=0:
  - clear pass_o and err_cnt_o to 0, set lane_sel_o=0, go to SETTLE.
  - start_i in any other state is ignored.
- SETTLE: prbs_en_o=1. Lasts exactly SETTLE_CYC cycles. prbs_err_i is ignored, because the checker powers up flagging error and needs history bits plus a 2-cycle pipeline. Then go to CHECK.
- CHECK: prbs_en_o=1. Lasts exactly CHECK_CYC cycles. Each cycle with prbs_err_i=1 increments the active counter, saturating at 2^ERR_CNT_W−1. Then go to NEXT.
- NEXT: one cycle, prbs_en_o=0.
  - Write the active counter into err_cnt_o for lane lane_sel_o.
  - Set pass_o[lane_sel_o] = (count == 0), then clear the active counter.
  - If lane_sel_o == NLANES−1, go to DONE. Otherwise increment lane_sel_o and go to SETTLE.
- DONE: one cycle, done_o=1, prbs_en_o=0. Then go to IDLE; lane_sel_o holds.
- Abort:
  - abort_i=1 in SETTLE, CHECK or NEXT goes to IDLE next cycle with prbs_en_o=0 and no done_o.
  - Results of lanes already completed are kept. The current and later lanes read pass=0, count=0.
  - abort_i in NEXT discards that cycle's result write.
  - abort_i together with start_i in IDLE: abort wins and the block stays IDLE.
- Results hold unchanged in IDLE until the next accepted start.
- Only one counter of ERR_CNT_W bits exists; results live in a register bank.

## Timing
- Reset values: prbs_en_o=0, lane_sel_o=0, busy_o=0, done_o=0, pass_o=0, err_cnt_o=0, state IDLE, counters 0.
- All outputs are registered. No combinational path runs from inputs to outputs.
- Latency, with start_i accepted at cycle T:
  - SETTLE begins at T+1, where busy_o=1 and prbs_en_o=1.
  - done_o=1 at cycle T+1+NLANES*(SETTLE_CYC+CHECK_CYC+1).
  - With defaults this is T+4165.
- busy_o falls in the cycle after done_o, and in the cycle after an accepted abort.
- prbs_en_o is low for exactly one cycle between consecutive lanes (NEXT).
- Reset asserted mid-scan forces all reset values immediately (asynchronous); results are lost.

## Structure
- Package prbs_ctrl_pkg holds:
  - state encoding (enumerated IDLE/SETTLE/CHECK/NEXT/DONE),
  - clog2-based LSEL_W helper,
  - minimum-settle constant (3).
- Sub-module prbs_sat_cnt: generic saturating up-counter with synchronous clear, enable and WIDTH parameter. Instantiated once for errors and reused, with its own width, as the SETTLE/CHECK cycle timer.
- The top level holds the FSM, the result bank and the lane select.

## Test plan
Bench parameters: NLANES=4, SETTLE_CYC=4, CHECK_CYC=16, ERR_CNT_W=8, unless a line states otherwise.
- Reset: hold resetn_i=0, toggle start_i -> all outputs 0. Release reset -> stays IDLE.
- Clean scan: start_i at T, prbs_err_i=1 only during SETTLE -> done_o at exactly T+85, pass_o=4'b1111, all counts 0, lane_sel_o steps 0,1,2,3, prbs_en_o low at T+21/42/63.
- Lane-2 errors: prbs_err_i=1 for 3 separate CHECK cycles of lane 2 -> pass_o=4'b1011, lane 2 count=3, others 0.
- Saturation: ERR_CNT_W=4, prbs_err_i=1 for all 16 CHECK cycles of lane 0 -> lane 0 count=15, pass_o[0]=0.
- Abort in lane 1 CHECK: -> IDLE next cycle, prbs_en_o=0, no done_o, pass_o=4'b0001.
- Precedence and reset:
  - start_i with abort_i in IDLE -> stays IDLE.
  - start_i during a scan -> ignored, done timing unchanged.
  - resetn_i pulsed during lane 3 -> immediate reset values.
